// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11/DHT22 reader: state codes, error codes,
// timing constants in microseconds and the frame checksum.
package dht_pkg;

   typedef enum logic [3:0] {
      OCIOSO       = 4'd0,
      INICIO_BAIXO = 4'd1,
      LIBERA       = 4'd2,
      RESP_BAIXO   = 4'd3,
      RESP_ALTO    = 4'd4,
      BIT_BAIXO    = 4'd5,
      BIT_ALTO     = 4'd6,
      VERIFICA     = 4'd7,
      ESPERA       = 4'd8,
      FIM          = 4'd9
   } estado_t;

   typedef enum logic [1:0] {
      ERRO_NENHUM      = 2'd0,
      ERRO_SEM_RESP    = 2'd1,
      ERRO_TIMEOUT_BIT = 2'd2,
      ERRO_CHECKSUM    = 2'd3
   } erro_t;

   localparam int US_INICIO_DHT11 = 18000;
   localparam int US_INICIO_DHT22 = 1000;
   localparam int US_LIBERA       = 100;
   localparam int US_TIMEOUT      = 200;
   localparam int US_LIMIAR_BIT   = 40;

   // Frame is {b0,b1,b2,b3,b4}; b4 is the 8-bit sum of the first four.
   function automatic logic checksum_ok(input logic [39:0] q);
      logic [7:0] soma;
      soma = q[39:32] + q[31:24] + q[23:16] + q[15:8];
      return soma == q[7:0];
   endfunction

endpackage

// File: rtl/dht_sincronizador.sv
// Two-flop synchronizer for the asynchronous sensor line; resets to the
// idle (pulled-up) level.
module dht_sincronizador #(
   parameter logic VALOR_RESET = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= VALOR_RESET;
         q    <= VALOR_RESET;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/dht_leitor.sv
// Single-wire DHT11/DHT22 reader: issues the start pulse, decodes the 40-bit
// frame by high-time measurement, checks the sum and retries on failure.
module dht_leitor
   import dht_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int MODO           = 0,
   parameter int MAX_TENTATIVAS = 2,
   parameter int ESPERA_US      = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   inout  wire         dht_bus,
   output logic [15:0] umidade,
   output logic [15:0] temperatura,
   output logic        pronto,
   output logic        valido,
   output logic [1:0]  erro,
   output logic [3:0]  db_estado
);

   localparam int     TPU      = CLK_HZ / 1_000_000;
   localparam int     CW       = $clog2(US_INICIO_DHT11 * TPU + 1);
   localparam longint CNT_SAT  = (longint'(1) << CW) - 1;

   // Long waits (e.g. a large ESPERA_US) clamp to the counter's ceiling.
   function automatic logic [CW-1:0] ticks(input longint us);
      longint t;
      t = us * TPU;
      if (t > CNT_SAT) t = CNT_SAT;
      return t[CW-1:0];
   endfunction

   localparam logic [CW-1:0] T_INICIO = ticks((MODO == 1) ? US_INICIO_DHT22 : US_INICIO_DHT11);
   localparam logic [CW-1:0] T_LIBERA = ticks(US_LIBERA);
   localparam logic [CW-1:0] T_TMO    = ticks(US_TIMEOUT);
   localparam logic [CW-1:0] T_LIMIAR = ticks(US_LIMIAR_BIT);
   localparam logic [CW-1:0] T_ESPERA = ticks(ESPERA_US);
   localparam logic [2:0]    ULTIMA   = 3'(MAX_TENTATIVAS - 1);

   estado_t       estado, estado_nx;
   erro_t         cod, fim_cod;
   logic [CW-1:0] cnt;
   logic [39:0]   dados;
   logic [5:0]    nbits;
   logic [2:0]    tent;
   logic          s, s_ant;
   logic          desloca, bit_nx, falha, soma_ok;

   dht_sincronizador u_sinc (
      .clock (clock),
      .reset (reset),
      .d     (dht_bus),
      .q     (s)
   );

   // Reset gates the driver directly so the line is freed without a clock.
   assign dht_bus   = (reset && estado == INICIO_BAIXO) ? 1'b0 : 1'bz;
   assign db_estado = estado;
   assign soma_ok   = checksum_ok(dados);

   always_comb begin
      estado_nx = estado;
      desloca   = 1'b0;
      bit_nx    = (cnt > T_LIMIAR);
      falha     = 1'b0;
      cod       = ERRO_NENHUM;
      fim_cod   = ERRO_NENHUM;
      case (estado)
         OCIOSO:       if (start) estado_nx = INICIO_BAIXO;
         INICIO_BAIXO: if (cnt >= T_INICIO - 1'b1) estado_nx = LIBERA;
         // Edge, not level: the synchronizer still holds our own low here.
         LIBERA: begin
            if (s_ant && !s) estado_nx = RESP_BAIXO;
            else if (cnt >= T_LIBERA - 1'b1) begin falha = 1'b1; cod = ERRO_SEM_RESP; end
         end
         RESP_BAIXO: begin
            if (s) estado_nx = RESP_ALTO;
            else if (cnt >= T_TMO) begin falha = 1'b1; cod = ERRO_SEM_RESP; end
         end
         RESP_ALTO: begin
            if (!s) estado_nx = BIT_BAIXO;
            else if (cnt >= T_TMO) begin falha = 1'b1; cod = ERRO_SEM_RESP; end
         end
         BIT_BAIXO: begin
            if (s) estado_nx = BIT_ALTO;
            else if (cnt >= T_TMO) begin falha = 1'b1; cod = ERRO_TIMEOUT_BIT; end
         end
         BIT_ALTO: begin
            if (!s) begin
               desloca   = 1'b1;
               estado_nx = (nbits == 6'd39) ? VERIFICA : BIT_BAIXO;
            end else if (cnt >= T_TMO) begin
               falha = 1'b1;
               cod   = ERRO_TIMEOUT_BIT;
            end
         end
         VERIFICA: begin
            if (soma_ok) estado_nx = FIM;
            else begin falha = 1'b1; cod = ERRO_CHECKSUM; end
         end
         ESPERA:  if (cnt >= T_ESPERA - 1'b1) estado_nx = INICIO_BAIXO;
         FIM:     estado_nx = OCIOSO;
         default: estado_nx = OCIOSO;
      endcase
      if (falha) begin
         fim_cod   = cod;
         estado_nx = (tent >= ULTIMA) ? FIM : ESPERA;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado      <= OCIOSO;
         s_ant       <= 1'b1;
         cnt         <= '0;
         dados       <= '0;
         nbits       <= '0;
         tent        <= '0;
         umidade     <= '0;
         temperatura <= '0;
         pronto      <= 1'b0;
         valido      <= 1'b0;
         erro        <= '0;
      end else begin
         estado <= estado_nx;
         s_ant  <= s;
         if (estado_nx != estado)       cnt <= '0;
         else if (cnt != {CW{1'b1}})    cnt <= cnt + 1'b1;
         pronto <= (estado_nx == FIM);
         if (estado_nx == FIM) begin
            erro   <= fim_cod;
            valido <= (fim_cod == ERRO_NENHUM);
         end
         if (estado == OCIOSO)                  tent <= '0;
         else if (falha && estado_nx == ESPERA) tent <= tent + 1'b1;
         if (estado == LIBERA) nbits <= '0;
         else if (desloca) begin
            dados <= {dados[38:0], bit_nx};
            nbits <= nbits + 1'b1;
         end
         if (estado == VERIFICA && soma_ok) begin
            umidade     <= dados[39:24];
            temperatura <= dados[23:8];
         end
      end
   end

endmodule

// File: tb/tb_dht_leitor.sv
// Directed bench: two readers (DHT11 single-try, DHT22 two-try) at 1 MHz so
// one tick is one microsecond, each with its own behavioural sensor.
`timescale 1ns/1ps
module tb_dht_leitor;

   logic clk = 1'b0;
   always #500 clk = ~clk;

   logic rst_a, rst_b, start_a, start_b, sens_a, sens_b;
   wire  bus_a, bus_b;
   pullup (bus_a);
   pullup (bus_b);
   assign bus_a = sens_a ? 1'b0 : 1'bz;
   assign bus_b = sens_b ? 1'b0 : 1'bz;

   logic [15:0] um_a, tp_a, um_b, tp_b;
   logic        pronto_a, valido_a, pronto_b, valido_b;
   logic [1:0]  erro_a, erro_b;
   logic [3:0]  est_a, est_b;

   dht_leitor #(.CLK_HZ(1_000_000), .MODO(0), .MAX_TENTATIVAS(1), .ESPERA_US(1000)) dut_a (
      .clock(clk), .reset(rst_a), .start(start_a), .dht_bus(bus_a), .umidade(um_a),
      .temperatura(tp_a), .pronto(pronto_a), .valido(valido_a), .erro(erro_a), .db_estado(est_a));

   dht_leitor #(.CLK_HZ(1_000_000), .MODO(1), .MAX_TENTATIVAS(2), .ESPERA_US(1000)) dut_b (
      .clock(clk), .reset(rst_b), .start(start_b), .dht_bus(bus_b), .umidade(um_b),
      .temperatura(tp_b), .pronto(pronto_b), .valido(valido_b), .erro(erro_b), .db_estado(est_b));

   int np_a = 0, np_b = 0;
   always @(posedge clk) begin
      if (pronto_a) np_a <= np_a + 1;
      if (pronto_b) np_b <= np_b + 1;
   end

   int ntot = 0, npass = 0, nfail = 0;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic rd(input bit sel);
      return sel ? bus_b : bus_a;
   endfunction

   task automatic set_sens(input bit sel, input logic v);
      if (sel) sens_b = v; else sens_a = v;
   endtask

   task automatic espera(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input bit sel);
      @(negedge clk);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // Counts high cycles before the next host low, then the low length.
   task automatic low_pulse(input bit sel, output int gap, output int len);
      gap = 0;
      while (rd(sel) !== 1'b0 && gap < 40000) begin @(negedge clk); gap++; end
      len = 0;
      while (rd(sel) !== 1'b1 && len < 40000) begin @(negedge clk); len++; end
   endtask

   // Answers a host start: 80 low / 80 high, then per bit 50 low and 26 or 70 high.
   task automatic sensor(input bit sel, input logic [39:0] f, input int nbits,
                         output int low_len, output bit ok);
      int g;
      ok = 1'b0;
      low_pulse(sel, g, low_len);
      if (g >= 40000 || low_len >= 40000) return;
      espera(30);
      set_sens(sel, 1'b1); espera(80);
      set_sens(sel, 1'b0); espera(80);
      for (int i = 0; i < nbits; i++) begin
         set_sens(sel, 1'b1); espera(50);
         set_sens(sel, 1'b0); espera(f[39-i] ? 70 : 26);
      end
      if (nbits == 40) begin
         set_sens(sel, 1'b1); espera(50);
         set_sens(sel, 1'b0);
      end
      ok = 1'b1;
   endtask

   task automatic wait_pronto(input bit sel, input int antes, output int ciclos, output bit ok);
      ciclos = 0;
      while ((sel ? np_b : np_a) == antes && ciclos < 40000) begin @(negedge clk); ciclos++; end
      ok = (ciclos < 40000);
   endtask

   initial begin
      int  len, cy, g2, l1, l2, b0;
      bit  ok;
      rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
      sens_a = 1'b0; sens_b = 1'b0;
      espera(3);
      chk("rst_estado", est_a, 4'd0);
      chk("rst_pronto", pronto_a, 1'b0);
      chk("rst_valido", valido_a, 1'b0);
      chk("rst_erro", erro_a, 2'd0);
      chk("rst_umidade", um_a, 16'h0);
      chk("rst_temp", tp_a, 16'h0);
      chk("rst_bus", bus_a, 1'b1);
      rst_a = 1'b1; rst_b = 1'b1;
      espera(3);

      // DHT11 good frame
      b0 = np_a;
      pulse_start(0);
      sensor(0, 40'h3700_1A00_51, 40, len, ok);
      chk("a1_sensor_ok", ok, 1'b1);
      chk("a1_start_18ms", (len >= 17999 && len <= 18001), 1'b1);
      wait_pronto(0, b0, cy, ok);
      chk("a1_pronto_seen", ok, 1'b1);
      chk("a1_valido", valido_a, 1'b1);
      chk("a1_erro", erro_a, 2'd0);
      chk("a1_umidade", um_a, 16'h3700);
      chk("a1_temp", tp_a, 16'h1A00);
      espera(5);
      chk("a1_one_pronto", np_a - b0, 1);

      // DHT11 bad checksum, single try: old readings held
      b0 = np_a;
      pulse_start(0);
      sensor(0, 40'h12_34_5a_bc_de, 40, len, ok);
      wait_pronto(0, b0, cy, ok);
      chk("a2_pronto_seen", ok, 1'b1);
      chk("a2_erro", erro_a, 2'd3);
      chk("a2_valido", valido_a, 1'b0);
      chk("a2_umidade_kept", um_a, 16'h3700);
      chk("a2_temp_kept", tp_a, 16'h1A00);
      espera(5);
      chk("a2_one_pronto", np_a - b0, 1);

      // DHT22 good frame, negative temperature
      b0 = np_b;
      pulse_start(1);
      sensor(1, 40'h028C_8065_73, 40, len, ok);
      chk("b1_sensor_ok", ok, 1'b1);
      chk("b1_start_1ms", (len >= 999 && len <= 1001), 1'b1);
      wait_pronto(1, b0, cy, ok);
      chk("b1_pronto_seen", ok, 1'b1);
      chk("b1_temp", tp_b, 16'h8065);
      chk("b1_umidade", um_b, 16'h028C);
      chk("b1_valido", valido_b, 1'b1);
      chk("b1_erro", erro_b, 2'd0);

      // No sensor: two start pulses, gap = 100 us listen + 1000 us wait
      b0 = np_b;
      pulse_start(1);
      low_pulse(1, g2, l1);
      low_pulse(1, g2, l2);
      chk("b2_pulse1_len", (l1 >= 999 && l1 <= 1001), 1'b1);
      chk("b2_gap", (g2 >= 1099 && g2 <= 1101), 1'b1);
      chk("b2_pulse2_len", (l2 >= 999 && l2 <= 1001), 1'b1);
      wait_pronto(1, b0, cy, ok);
      chk("b2_pronto_seen", ok, 1'b1);
      chk("b2_erro", erro_b, 2'd1);
      chk("b2_valido", valido_b, 1'b0);
      chk("b2_temp_kept", tp_b, 16'h8065);
      espera(5);
      chk("b2_one_pronto", np_b - b0, 1);

      // Sensor stalls high after bit 20 on both tries
      b0 = np_b;
      pulse_start(1);
      sensor(1, 40'h0, 20, len, ok);
      chk("b3_try1_ok", ok, 1'b1);
      sensor(1, 40'h0, 20, len, ok);
      chk("b3_try2_ok", ok, 1'b1);
      wait_pronto(1, b0, cy, ok);
      chk("b3_timeout_200us", (cy >= 170 && cy <= 190), 1'b1);
      chk("b3_erro", erro_b, 2'd2);
      chk("b3_valido", valido_b, 1'b0);
      espera(5);
      chk("b3_one_pronto", np_b - b0, 1);

      // Reset during the start pulse, then a clean read
      pulse_start(1);
      espera(500);
      chk("b4_bus_low", bus_b, 1'b0);
      rst_b = 1'b0;
      #1;
      chk("b4_bus_freed", bus_b, 1'b1);
      chk("b4_estado", est_b, 4'd0);
      chk("b4_umidade", um_b, 16'h0);
      chk("b4_temp", tp_b, 16'h0);
      chk("b4_erro", erro_b, 2'd0);
      chk("b4_valido", valido_b, 1'b0);
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      espera(2);
      rst_b = 1'b1;
      espera(3);
      chk("b4_start_lost", est_b, 4'd0);
      b0 = np_b;
      pulse_start(1);
      sensor(1, 40'h4B00_1900_64, 40, len, ok);
      chk("b5_sensor_ok", ok, 1'b1);
      wait_pronto(1, b0, cy, ok);
      chk("b5_pronto_seen", ok, 1'b1);
      chk("b5_umidade", um_b, 16'h4B00);
      chk("b5_temp", tp_b, 16'h1900);
      chk("b5_valido", valido_b, 1'b1);
      chk("b5_erro", erro_b, 2'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
